alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_if.sv | 28 ++
 rtl/alu_result_stage.sv | 113 +++++++++++
 tb/tb_alu_result_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and writeback.
// slave:  the result stage side (accepts ALU results, offers the head entry).
// master: the driving side (ALU producer plus writeback consumer).
interface alu_result_stage_if #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int REG_ADDR_BITS  = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_BUS_WIDTH-1:0] in_result;
    logic                      in_z;
    logic [REG_ADDR_BITS-1:0]  in_dest;
    logic                      in_set_flag;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_BUS_WIDTH-1:0] out_data;
    logic [REG_ADDR_BITS-1:0]  out_dest;

    modport slave (
        input  in_valid, in_result, in_z, in_dest, in_set_flag, out_ready,
        output in_ready, out_valid, out_data, out_dest
    );

    modport master (
        output in_valid, in_result, in_z, in_dest, in_set_flag, out_ready,
        input  in_ready, out_valid, out_data, out_dest
    );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry skid FIFO between the ALU and register writeback, plus the
// architectural zero flag register updated on accepted results.
//
// state | meaning
// EMPTY | no entries held, out_valid low, in_ready high
// ONE   | one entry held, push and pop both possible (simultaneous keeps ONE)
// FULL  | two entries held, in_ready low, only a pop can leave
//
// The state encoding equals the occupancy, so the state register doubles as
// the count output.
module alu_result_stage #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int REG_ADDR_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_result_stage_if.slave    bus,
    output logic                 zero_flag,
    output logic [1:0]           count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [DATA_BUS_WIDTH-1:0] mem_data_q [2];
    logic [DATA_BUS_WIDTH-1:0] mem_data_d [2];
    logic [REG_ADDR_BITS-1:0]  mem_dest_q [2];
    logic [REG_ADDR_BITS-1:0]  mem_dest_d [2];
    logic                      zero_flag_q, zero_flag_d;

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;

    // Handshake qualifiers: both ready and valid come from registered state only.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        push      = bus.in_valid && in_ready;
        pop       = out_valid && bus.out_ready;
    end

    // Occupancy FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push) state_d = ONE;
            end
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL: begin
                if (pop) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Storage, pointers and zero flag next-state; inputs only matter on a push.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_data_d  = mem_data_q;
        mem_dest_d  = mem_dest_q;
        zero_flag_d = zero_flag_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = bus.in_result;
            mem_dest_d[wr_ptr_q] = bus.in_dest;
            wr_ptr_d             = ~wr_ptr_q;
            if (bus.in_set_flag) zero_flag_d = bus.in_z;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // State register; reset wins over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            mem_data_q  <= '{default: '0};
            mem_dest_q  <= '{default: '0};
            zero_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_data_q  <= mem_data_d;
            mem_dest_q  <= mem_dest_d;
            zero_flag_q <= zero_flag_d;
        end
    end

    // Outputs: head entry straight from storage, no input bypass.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem_data_q[rd_ptr_q];
    assign bus.out_dest  = mem_dest_q[rd_ptr_q];
    assign zero_flag     = zero_flag_q;
    assign count         = state_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and randomized checks of the ALU result stage against a queue model.
module tb_alu_result_stage;
    localparam int DW = 16;
    localparam int AW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       zero_flag;
    logic [1:0] count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alu_result_stage_if #(.DATA_BUS_WIDTH(DW), .REG_ADDR_BITS(AW)) bus ();

    alu_result_stage #(.DATA_BUS_WIDTH(DW), .REG_ADDR_BITS(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .zero_flag (zero_flag),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a,
                         input logic z, input logic sf, input logic ordy);
        bus.in_valid    = v;
        bus.in_result   = d;
        bus.in_dest     = a;
        bus.in_z        = z;
        bus.in_set_flag = sf;
        bus.out_ready   = ordy;
    endtask

    logic [DW+AW-1:0] q[$];
    logic             zf_m;
    logic             push_m, pop_m;
    logic [DW+AW-1:0] head;
    int               bias_in, bias_out;

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_count", count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_zf", zero_flag, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_dest", bus.out_dest, 0);

        // single push, one-cycle latency
        drive(1'b1, 16'h1234, 3'd3, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("p1_out_valid", bus.out_valid, 1);
        chk("p1_out_data", bus.out_data, 16'h1234);
        chk("p1_out_dest", bus.out_dest, 3);
        chk("p1_count", count, 1);
        chk("p1_zf", zero_flag, 0);
        tick();
        chk("p1_hold_data", bus.out_data, 16'h1234);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // fill, refused third push, drain in order
        drive(1'b1, 16'h0001, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fill1_count", count, 1);
        drive(1'b1, 16'h0002, 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fill2_count", count, 2);
        chk("fill2_in_ready", bus.in_ready, 0);
        drive(1'b1, 16'h0003, 3'd4, 1'b0, 1'b0, 1'b0);
        tick();
        chk("full_count", count, 2);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_head", bus.out_data, 16'h0001);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("drain1_data", bus.out_data, 16'h0001);
        chk("drain1_dest", bus.out_dest, 1);
        tick();
        chk("drain2_data", bus.out_data, 16'h0002);
        chk("drain2_dest", bus.out_dest, 2);
        chk("drain2_count", count, 1);
        tick();
        chk("drained_valid", bus.out_valid, 0);
        chk("drained_count", count, 0);

        // pop on empty has no effect; next push becomes head
        tick();
        chk("empty_pop_count", count, 0);
        drive(1'b1, 16'hAAAA, 3'd5, 1'b0, 1'b0, 1'b0);
        tick();
        chk("one_head", bus.out_data, 16'hAAAA);
        chk("one_dest", bus.out_dest, 5);

        // simultaneous push and pop in ONE
        drive(1'b1, 16'hBBBB, 3'd6, 1'b0, 1'b0, 1'b1);
        chk("pp_pop_data", bus.out_data, 16'hAAAA);
        tick();
        chk("pp_count", count, 1);
        chk("pp_head", bus.out_data, 16'hBBBB);
        chk("pp_dest", bus.out_dest, 6);
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("pp_empty", count, 0);
        chk("noflag_nopush", zero_flag, 0);

        // zero flag load then hold
        drive(1'b1, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("zf_set", zero_flag, 1);
        drive(1'b1, 16'h0005, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("zf_hold", zero_flag, 1);
        chk("zf_full", count, 2);

        // reset while full with push and pop requested
        rst = 1'b1;
        drive(1'b1, 16'h7777, 3'd7, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("mrst_count", count, 0);
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_zf", zero_flag, 0);

        // randomized traffic against a queue model
        q.delete();
        zf_m = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            chk("rnd_count", count, q.size());
            chk("rnd_in_ready", bus.in_ready, (q.size() < 2) ? 1 : 0);
            chk("rnd_out_valid", bus.out_valid, (q.size() != 0) ? 1 : 0);
            chk("rnd_zf", zero_flag, zf_m);
            if (q.size() != 0) begin
                head = q[0];
                chk("rnd_data", bus.out_data, head[DW+AW-1:AW]);
                chk("rnd_dest", bus.out_dest, head[AW-1:0]);
            end

            case ((i / 500) % 3)
                0:       begin bias_in = 80; bias_out = 30; end
                1:       begin bias_in = 50; bias_out = 50; end
                default: begin bias_in = 30; bias_out = 80; end
            endcase
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 99) < bias_in, DW'($urandom), AW'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 99) < bias_out);

            push_m = bus.in_valid && (q.size() < 2);
            pop_m  = (q.size() != 0) && bus.out_ready;
            tick();
            if (rst) begin
                q.delete();
                zf_m = 1'b0;
            end else begin
                if (pop_m) void'(q.pop_front());
                if (push_m) begin
                    q.push_back({bus.in_result, bus.in_dest});
                    if (bus.in_set_flag) zf_m = bus.in_z;
                end
            end
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
